// File: rtl/ccr_unit.sv
// Condition-code register plus a small shadow stack that preserves the CCR across
// nested interrupts; the top entry feeds the ALU restore path as freezedCCR.
module ccr_unit #(
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          ccrWriteEnable,
  input  logic          zeroFlagIn,
  input  logic          carryFlagIn,
  input  logic          overFlowFlagIn,
  input  logic          negativeFlagIn,
  input  logic          interruptFreeze,
  input  logic          rtiPop,
  output logic          zeroFlag,
  output logic          carryFlag,
  output logic          overFlowFlag,
  output logic          negativeFlag,
  output logic [3:0]    freezedCCR,
  output logic [DW-1:0] shadowDepth,
  output logic          shadowOverflow,
  output logic          shadowUnderflow
);

  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  logic [3:0]             ccr_q, ccr_d;
  logic [DEPTH-1:0][3:0]  stk_q, stk_d;
  logic [DW-1:0]          dep_q, dep_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic                   wr_en;
  logic [DW-1:0]          wr_sel;

  // Push captures ccrNext so the flags of the instruction completing alongside
  // the interrupt entry are included in the saved context.
  always_comb begin
    ccr_d  = ccrWriteEnable ? {negativeFlagIn, overFlowFlagIn, carryFlagIn, zeroFlagIn} : ccr_q;
    dep_d  = dep_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    wr_en  = 1'b0;
    wr_sel = dep_q;
    if (interruptFreeze && rtiPop) begin
      wr_en = 1'b1;
      if (dep_q != '0) begin
        wr_sel = dep_q - DW'(1);
      end else begin
        dep_d = DW'(1);
        unf_d = 1'b1;
      end
    end else if (interruptFreeze) begin
      if (dep_q == FULL) begin
        ovf_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        dep_d = dep_q + DW'(1);
      end
    end else if (rtiPop) begin
      if (dep_q == '0) unf_d = 1'b1;
      else             dep_d = dep_q - DW'(1);
    end
  end

  always_comb begin
    stk_d = stk_q;
    for (int i = 0; i < DEPTH; i++)
      if (wr_en && wr_sel == DW'(i)) stk_d[i] = ccr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_q <= '0;
      stk_q <= '0;
      dep_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!stall) begin
      ccr_q <= ccr_d;
      stk_q <= stk_d;
      dep_q <= dep_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_comb begin
    freezedCCR = 4'b0000;
    for (int i = 0; i < DEPTH; i++)
      if (dep_q == DW'(i+1)) freezedCCR = stk_q[i];
  end

  assign {negativeFlag, overFlowFlag, carryFlag, zeroFlag} = ccr_q;
  assign shadowDepth     = dep_q;
  assign shadowOverflow  = ovf_q;
  assign shadowUnderflow = unf_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Scoreboard bench for ccr_unit: a queue-based reference model predicts each cycle's
// registered outputs, which are compared one cycle after the stimulus is applied.
module tb_ccr_unit;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst, stall, we, zf, cf, of, nf, frz, pop;
  logic zo, co, oo, no;
  logic [3:0] fccr;
  logic [2:0] dep;
  logic ovf, unf;

  ccr_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ccrWriteEnable(we),
    .zeroFlagIn(zf), .carryFlagIn(cf), .overFlowFlagIn(of), .negativeFlagIn(nf),
    .interruptFreeze(frz), .rtiPop(pop),
    .zeroFlag(zo), .carryFlag(co), .overFlowFlag(oo), .negativeFlag(no),
    .freezedCCR(fccr), .shadowDepth(dep),
    .shadowOverflow(ovf), .shadowUnderflow(unf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ccr;
    logic [3:0] fccr;
    logic [2:0] dep;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_stk[$];
  logic [3:0] m_ccr;
  logic       m_ovf, m_unf;
  int         errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs, advance the model, queue the prediction, compare after the edge.
  task automatic step(input logic r, input logic s, input logic w, input logic [3:0] fl,
                      input logic fz, input logic p);
    logic [3:0] nxt;
    exp_t e, o;
    @(negedge clk);
    rst = r; stall = s; we = w; {nf, of, cf, zf} = fl; frz = fz; pop = p;
    nxt = w ? fl : m_ccr;
    if (r) begin
      m_ccr = 4'b0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (!s) begin
      if (fz && p) begin
        if (m_stk.size() > 0) m_stk[m_stk.size()-1] = nxt;
        else begin m_stk.push_back(nxt); m_unf = 1'b1; end
      end else if (fz) begin
        if (m_stk.size() == DEPTH) m_ovf = 1'b1;
        else m_stk.push_back(nxt);
      end else if (p) begin
        if (m_stk.size() == 0) m_unf = 1'b1;
        else void'(m_stk.pop_back());
      end
      m_ccr = nxt;
    end
    e.ccr  = m_ccr;
    e.fccr = (m_stk.size() > 0) ? m_stk[$] : 4'b0;
    e.dep  = 3'(m_stk.size());
    e.ovf  = m_ovf;
    e.unf  = m_unf;
    sb.push_back(e);
    @(posedge clk); #1;
    o = sb.pop_front();
    chk("ccr",   {4'b0, no, oo, co, zo}, {4'b0, o.ccr});
    chk("fccr",  {4'b0, fccr},           {4'b0, o.fccr});
    chk("depth", {5'b0, dep},            {5'b0, o.dep});
    chk("ovf",   {7'b0, ovf},            {7'b0, o.ovf});
    chk("unf",   {7'b0, unf},            {7'b0, o.unf});
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; we = 1'b0; {nf, of, cf, zf} = 4'b0; frz = 1'b0; pop = 1'b0;
    m_ccr = 4'b0; m_ovf = 1'b0; m_unf = 1'b0;
    step(1, 0, 0, 4'b0000, 0, 0);
    chk("rst_fccr_const", {4'b0, fccr}, 8'h00);
    step(0, 0, 1, 4'b1010, 0, 0);
    chk("n_flag_const", {7'b0, no}, 8'h01);
    step(0, 0, 1, 4'b0001, 0, 0);
    step(0, 0, 1, 4'b0100, 1, 0);
    chk("push_fccr_const", {4'b0, fccr}, 8'h04);
    step(0, 0, 1, 4'b0001, 0, 1);           // RTI restore with same-cycle pop
    for (int i = 0; i < 4; i++) step(0, 0, 1, 4'(1 << i), 1, 0);
    step(0, 0, 0, 4'b0000, 1, 0);           // fifth push overflows
    chk("ovf_top_const", {4'b0, fccr}, 8'h08);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'b0000, 0, 1);
    step(0, 0, 0, 4'b0000, 0, 1);           // underflow
    step(0, 0, 1, 4'b0011, 1, 0);
    step(0, 0, 1, 4'b0110, 1, 0);
    step(0, 0, 1, 4'b1111, 1, 1);           // replace top
    chk("swap_top_const", {4'b0, fccr}, 8'h0f);
    step(0, 0, 0, 4'b0000, 0, 1);
    chk("lower_const", {4'b0, fccr}, 8'h03);
    step(0, 0, 0, 4'b0000, 1, 1);           // push+pop at depth 1
    step(0, 0, 0, 4'b0000, 0, 1);
    step(0, 0, 0, 4'b0000, 1, 1);           // push+pop at depth 0
    step(0, 1, 1, 4'b1111, 1, 0);           // stalled
    step(0, 0, 0, 4'b0000, 0, 0);
    step(0, 0, 1, 4'b0101, 1, 0);
    step(0, 0, 1, 4'b1001, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4'b0000, 1, 0);
    step(0, 0, 0, 4'b0000, 0, 1);
    step(1, 0, 1, 4'b1111, 1, 0);           // reset beats push
    chk("rst_dep_const", {5'b0, dep}, 8'h00);
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0), 1'($urandom),
           4'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ccr_unit.md
# ccr_unit

Condition-code register and interrupt flag-shadow stack for the 16-bit pipeline. It registers the four flags produced by the ALU each cycle and feeds them back to the ALU flag inputs. On interrupt entry it pushes the current CCR onto a small shadow stack; on RTI it pops it. The top entry drives the ALU `freezedCCR` input, so the RTI restore path returns the correct flags even under nested interrupts.

## Interface
- `DEPTH`, 4, number of shadow-stack entries (nesting depth supported), ≥1
- `clk`  input  1  pipeline clock; all state updates on rising edge
- `rst`  input  1  synchronous, active-high reset
- `stall`  input  1  when 1, all state holds; every other input ignored
- `ccrWriteEnable`  input  1  latch ALU flag outputs this cycle
- `zeroFlagIn`, `carryFlagIn`, `overFlowFlagIn`, `negativeFlagIn`  input  1 each  ALU `*FlagOut` signals
- `interruptFreeze`  input  1  single-cycle pulse on interrupt entry; push CCR
- `rtiPop`  input  1  single-cycle pulse when RTI leaves EX; pop shadow stack
- `zeroFlag`, `carryFlag`, `overFlowFlag`, `negativeFlag`  output  1 each  registered CCR, to ALU flag inputs
- `freezedCCR`  output  4  top shadow entry {NF,OF,CF,ZF} = [3:0]; 4'b0000 when empty
- `shadowDepth`  output  $clog2(DEPTH+1)  number of valid entries
- `shadowOverflow`  output  1  sticky: push attempted while full
- `shadowUnderflow`  output  1  sticky: pop attempted while empty

## Operation
- State: CCR (4 bits), stack array `DEPTH` × 4, depth counter, two sticky error bits.
- CCR next value `ccrNext` = {negativeFlagIn, overFlowFlagIn, carryFlagIn, zeroFlagIn} if `ccrWriteEnable`, else current CCR. CCR loads `ccrNext` every non-stalled cycle.
- Push (`interruptFreeze`=1, `rtiPop`=0):
  - Stores `ccrNext`, so the same-cycle write of the completing instruction is included.
  - Writes to entry[depth]; depth increments.
- Pop (`rtiPop`=1, `interruptFreeze`=0): depth decrements. Popped entry contents are don't-care, but `freezedCCR` must show the new top, or 0 when empty.
- Simultaneous push and pop:
  - If depth > 0: top entry is replaced with `ccrNext`; depth unchanged.
  - If depth = 0: push only (depth becomes 1), and `shadowUnderflow` is set.
- Push when depth = DEPTH (and no pop): stack and depth unchanged; `shadowOverflow` ← 1.
- Pop when depth = 0: no change; `shadowUnderflow` ← 1.
- Sticky bits clear only on `rst`.
- CCR write is independent of push/pop. The RTI restore itself arrives through the ALU flag outputs with `ccrWriteEnable`=1. Same-cycle `rtiPop` is legal: the CCR takes the restored flags and the stack pops.
- `freezedCCR` = entry[depth-1] when depth > 0, else 4'b0000. It is purely combinational from registered state.

## Timing
- Reset (sync, `rst`=1 at rising edge) clears:
  - CCR = 0000, so all four flag outputs = 0
  - depth = 0, so `freezedCCR` = 0000
  - `shadowOverflow` = `shadowUnderflow` = 0
- `rst` has priority over `stall` and all other inputs. Reset mid-nesting discards all entries.
- Flag inputs to flag outputs: 1-cycle latency. No combinational path from any input to any output.
- Push/pop to `freezedCCR` / `shadowDepth` update: 1 cycle.
- `stall`=1 freezes everything, including sticky bits. Pulses presented during a stall are lost; upstream holds them until `stall`=0.
- Depth never wraps: it saturates at 0 and at `DEPTH`.

## Test plan
- Reset, then write flags 1010 with `ccrWriteEnable` → next cycle flag outputs = {N=1,O=0,C=1,Z=0}. `freezedCCR` = 0000, depth = 0.
- CCR = 0001; assert `interruptFreeze` with `ccrWriteEnable` and flags 0100 → CCR = 0100, `freezedCCR` = 0100, depth = 1.
- Nest with DEPTH=4: push 0001, 0010, 0100, 1000, then a fifth push → depth stays 4, `shadowOverflow` = 1, top = 1000. Four pops → `freezedCCR` sequence 0100, 0010, 0001, 0000.
- Depth = 0 with `rtiPop` → `shadowUnderflow` = 1, depth = 0. Depth = 2 with push and pop together, `ccrNext` = 1111 → depth = 2, top = 1111, lower entry unchanged.
- `stall` = 1 while `ccrWriteEnable`, `interruptFreeze` and flags 1111 are asserted → CCR and depth unchanged. Release the stall with idle inputs → still unchanged.
- Depth = 3 with `shadowOverflow` set; assert `rst` together with `interruptFreeze` → next cycle all outputs are 0, depth = 0, sticky bits cleared.
